// File: rtl/jk_ff_bank_if.sv
// Signal bundle for the JK flip-flop bank: update controls in, registered state out.
// The design uses the slave modport and the driver uses the master modport.
interface jk_ff_bank_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             enable;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [CW-1:0]    change_count;
    logic [WIDTH-1:0] sr_err;

    modport slave (
        input  enable, mode, j, k, err_clr,
        output q, qbar, change_count, sr_err
    );

    modport master (
        output enable, mode, j, k, err_clr,
        input  q, qbar, change_count, sr_err
    );
endinterface

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH flip-flops with runtime-selected JK/D/T/SR update rule,
// per-edge change count and sticky per-bit SR-violation flags.
module jk_ff_lane #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] mode_i,
    input  logic       j_i,
    input  logic       k_i,
    input  logic       clr_i,
    output logic       q_o,
    output logic       err_o,
    output logic       chg_o
);
    logic q_q, q_d;
    logic err_q, err_d;

    always_comb begin
        q_d   = q_q;
        err_d = err_q & ~clr_i;
        if (en_i) begin
            unique case (mode_i)
                2'b00: q_d = (j_i & ~q_q) | (~k_i & q_q);
                2'b01: q_d = j_i;
                2'b10: q_d = q_q ^ j_i;
                2'b11: begin
                    // J=K=1 is illegal in SR mode: hold Q, flag it; a fresh error beats ErrClr.
                    if (j_i & k_i) err_d = 1'b1;
                    else if (j_i)  q_d   = 1'b1;
                    else if (k_i)  q_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q   <= RST_VAL;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
        end
    end

    assign q_o   = q_q;
    assign err_o = err_q;
    assign chg_o = q_d ^ q_q;
endmodule

module jk_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    jk_ff_bank_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q, err, chg;
    logic [CW-1:0]    cnt_q, cnt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        jk_ff_lane #(.RST_VAL(RESET_VAL[i])) u_lane (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (bus.enable),
            .mode_i (bus.mode),
            .j_i    (bus.j[i]),
            .k_i    (bus.k[i]),
            .clr_i  (bus.err_clr),
            .q_o    (q[i]),
            .err_o  (err[i]),
            .chg_o  (chg[i])
        );
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < WIDTH; i++) cnt_d = cnt_d + CW'(chg[i]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bus.q            = q;
    assign bus.qbar         = ~q;
    assign bus.change_count = cnt_q;
    assign bus.sr_err       = err;
endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed bench for jk_ff_bank: two instances (RESET_VAL 00 and 3C) share stimulus;
// expected outputs are queued as each step is driven and checked after the edge.
module tb_jk_ff_bank;
    localparam int W = 8;

    typedef struct {
        logic [7:0] q;
        logic [3:0] cc;
        logic [7:0] err;
        bit         chk1;
        logic [7:0] q1;
        logic [3:0] cc1;
        logic [7:0] err1;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    jk_ff_bank_if #(.WIDTH(W)) bus0 ();
    jk_ff_bank_if #(.WIDTH(W)) bus1 ();

    assign bus1.enable  = bus0.enable;
    assign bus1.mode    = bus0.mode;
    assign bus1.j       = bus0.j;
    assign bus1.k       = bus0.k;
    assign bus1.err_clr = bus0.err_clr;

    jk_ff_bank #(.WIDTH(W), .RESET_VAL(8'h00)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
    jk_ff_bank #(.WIDTH(W), .RESET_VAL(8'h3C)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %h exp %h", tag, got, want);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [1:0] md,
                        input logic [7:0] jv, input logic [7:0] kv, input logic clr,
                        input logic [7:0] eq, input logic [3:0] ecc, input logic [7:0] eerr,
                        input bit c1, input logic [7:0] eq1, input logic [3:0] ecc1,
                        input logic [7:0] eerr1);
        exp_t e;
        rst          = r;
        bus0.enable  = en;
        bus0.mode    = md;
        bus0.j       = jv;
        bus0.k       = kv;
        bus0.err_clr = clr;
        sb.push_back('{eq, ecc, eerr, c1, eq1, ecc1, eerr1});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("q",    bus0.q,                   e.q);
        chk("qbar", bus0.qbar,                ~e.q);
        chk("cc",   8'(bus0.change_count),    8'(e.cc));
        chk("err",  bus0.sr_err,              e.err);
        if (e.chk1) begin
            chk("q1",    bus1.q,                e.q1);
            chk("qbar1", bus1.qbar,             ~e.q1);
            chk("cc1",   8'(bus1.change_count), 8'(e.cc1));
            chk("err1",  bus1.sr_err,           e.err1);
        end
    endtask

    initial begin
        @(negedge clk);
        //    rst en md   J      K      clr  Q      CC  SrErr  chk1 Q1     CC1 SrErr1
        step(1, 1, 2'b00, 8'hFF, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 8'h3C, 0, 8'h00);
        // JK toggle from 00
        step(0, 1, 2'b00, 8'hFF, 8'hFF, 0, 8'hFF, 8, 8'h00, 1, 8'hC3, 8, 8'h00);
        step(0, 1, 2'b00, 8'hFF, 8'hFF, 0, 8'h00, 8, 8'h00, 0, 8'h00, 0, 8'h00);
        step(0, 1, 2'b00, 8'hFF, 8'hFF, 0, 8'hFF, 8, 8'h00, 0, 8'h00, 0, 8'h00);
        // hold while disabled, then D load
        step(0, 0, 2'b00, 8'hFF, 8'h00, 0, 8'hFF, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        step(0, 1, 2'b01, 8'hA5, 8'h00, 0, 8'hA5, 4, 8'h00, 0, 8'h00, 0, 8'h00);
        // T mode
        step(0, 1, 2'b10, 8'h0F, 8'h00, 0, 8'hAA, 4, 8'h00, 0, 8'h00, 0, 8'h00);
        step(0, 1, 2'b10, 8'h00, 8'h00, 0, 8'hAA, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        // SR mode, violation vs ErrClr
        step(0, 1, 2'b11, 8'h0F, 8'h03, 0, 8'hAE, 1, 8'h03, 0, 8'h00, 0, 8'h00);
        step(0, 1, 2'b11, 8'h0F, 8'h03, 1, 8'hAE, 0, 8'h03, 0, 8'h00, 0, 8'h00);
        step(0, 1, 2'b11, 8'h00, 8'h00, 1, 8'hAE, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        // all-bit violation, then ErrClr with Enable=0, then disabled SR input sets nothing
        step(0, 1, 2'b11, 8'hFF, 8'hFF, 0, 8'hAE, 0, 8'hFF, 0, 8'h00, 0, 8'h00);
        step(0, 0, 2'b11, 8'h00, 8'h00, 1, 8'hAE, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        step(0, 0, 2'b11, 8'hFF, 8'hFF, 0, 8'hAE, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        // SrErr=03, JK toggle, then mid-operation reset and recovery
        step(0, 1, 2'b11, 8'h03, 8'h03, 0, 8'hAE, 0, 8'h03, 0, 8'h00, 0, 8'h00);
        step(0, 1, 2'b00, 8'hFF, 8'hFF, 0, 8'h51, 8, 8'h03, 0, 8'h00, 0, 8'h00);
        step(1, 1, 2'b00, 8'hFF, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 8'h3C, 0, 8'h00);
        step(0, 1, 2'b00, 8'hFF, 8'hFF, 0, 8'hFF, 8, 8'h00, 1, 8'hC3, 8, 8'h00);
        // mixed JK: set low nibble, clear high nibble, from FF
        step(0, 1, 2'b00, 8'h0F, 8'hF0, 0, 8'h0F, 4, 8'h00, 0, 8'h00, 0, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
